mkio_rt_tx: RTL and testbench

// Parametrised MKIO (GOST R 52070 / MIL-STD-1553) remote-terminal transmit responder.

---
 rtl/mkio_rt_tx.sv | 163 ++++++++++++++++
 tb/tb_mkio_rt_tx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mkio_rt_tx.sv
// mkio_rt_tx: MKIO remote-terminal transmit responder.
// Answers a valid transmit command with a status word followed by words from per-subaddress buffers.
module mkio_rt_tx #(
   parameter logic [4:0] ADDRESS      = 5'd1,
   parameter int         NUM_SA       = 4,
   parameter logic [7:0] PAUSE_CYCLES = 8'd20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] rx_data,
   input  logic        p_error,
   input  logic        sreq,
   input  logic        ss_flag,
   input  logic        t_flag,
   input  logic        dbca,
   input  logic        wr_en,
   input  logic [4:0]  wr_sa,
   input  logic [4:0]  wr_addr,
   input  logic [15:0] wr_data,
   output logic [15:0] tx_data,
   output logic        tx_cd,
   output logic        tx_valid,
   input  logic        tx_ack,
   output logic        busy,
   output logic        done,
   output logic        cmd_err
);
   localparam int AW = $clog2(NUM_SA * 32);
   localparam logic [4:0] NSA = 5'(NUM_SA);
   typedef enum logic [2:0] {IDLE, DECODE, GAP, SEND_SW, READ, SEND_DW, DONE} state_t;
   state_t      state_q, state_d;
   logic [15:0] cmd_q, cmd_d, tx_data_q, tx_data_d, rd_q;
   logic [15:0] mem [NUM_SA*32];
   logic [4:0]  sa_q, sa_d, n_q, n_d, idx_q, idx_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        perr_q, perr_d, bcr_q, bcr_d, ds_q, ds_d;
   logic        tx_cd_q, tx_cd_d, tx_valid_q, tx_valid_d, busy_q, busy_d;
   logic        done_q, done_d, cmd_err_q, cmd_err_d;
   logic        sa_ok, me;
   logic [AW-1:0] wr_idx, rd_idx;
   // Mode-code subaddresses 0 and 31 get a plain status; unimplemented ones flag ME.
   assign sa_ok  = cmd_q[9:5] != 5'd0 && cmd_q[9:5] != 5'd31;
   assign me     = sa_ok && cmd_q[9:5] > NSA;
   assign wr_idx = AW'({wr_sa - 5'd1, wr_addr});
   assign rd_idx = AW'({sa_q - 5'd1, idx_q});
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      perr_d     = perr_q;
      bcr_d      = bcr_q;
      ds_d       = ds_q;
      sa_d       = sa_q;
      n_d        = n_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      tx_data_d  = tx_data_q;
      tx_cd_d    = tx_cd_q;
      tx_valid_d = tx_valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      cmd_err_d  = 1'b0;
      if (start) begin
         state_d    = DECODE;
         cmd_d      = rx_data;
         perr_d     = p_error;
         tx_valid_d = 1'b0;
         busy_d     = 1'b1;
      end else begin
         case (state_q)
            DECODE: begin
               state_d = IDLE;
               busy_d  = 1'b0;
               if (perr_q) cmd_err_d = 1'b1;
               else if (cmd_q[15:11] == 5'd31) bcr_d = 1'b1;
               else if (cmd_q[15:11] == ADDRESS && cmd_q[10]) begin
                  state_d   = GAP;
                  busy_d    = 1'b1;
                  sa_d      = cmd_q[9:5];
                  n_d       = cmd_q[4:0] - 5'd1;
                  ds_d      = sa_ok && !me;
                  cnt_d     = PAUSE_CYCLES - 8'd2;
                  tx_data_d = {ADDRESS, me, 1'b0, sreq, 3'b000, bcr_q, 1'b0, ss_flag, dbca, t_flag};
                  tx_cd_d   = 1'b1;
               end
            end
            GAP: begin
               state_d    = cnt_q == 8'd0 ? SEND_SW : GAP;
               tx_valid_d = cnt_q == 8'd0;
               cnt_d      = cnt_q - 8'd1;
            end
            SEND_SW: if (tx_ack) begin
               tx_valid_d = 1'b0;
               bcr_d      = bcr_q & ~tx_data_q[4];
               idx_d      = 5'd0;
               state_d    = ds_q ? READ : DONE;
               done_d     = !ds_q;
               busy_d     = ds_q;
            end
            READ: state_d = SEND_DW;
            SEND_DW: if (!tx_valid_q) begin
               tx_valid_d = 1'b1;
               tx_data_d  = rd_q;
               tx_cd_d    = 1'b0;
            end else if (tx_ack) begin
               tx_valid_d = 1'b0;
               idx_d      = idx_q + 5'd1;
               state_d    = idx_q == n_q ? DONE : READ;
               done_d     = idx_q == n_q;
               busy_d     = idx_q != n_q;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cmd_q      <= '0;
         perr_q     <= 1'b0;
         bcr_q      <= 1'b0;
         ds_q       <= 1'b0;
         sa_q       <= '0;
         n_q        <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         tx_data_q  <= '0;
         tx_cd_q    <= 1'b0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         perr_q     <= perr_d;
         bcr_q      <= bcr_d;
         ds_q       <= ds_d;
         sa_q       <= sa_d;
         n_q        <= n_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         tx_cd_q    <= tx_cd_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         cmd_err_q  <= cmd_err_d;
      end
   end
   // Buffer survives reset; a read in READ sees the old word if written the same cycle.
   always_ff @(posedge clk) begin
      if (wr_en && wr_sa != 5'd0 && wr_sa <= NSA) mem[wr_idx] <= wr_data;
      if (state_q == READ) rd_q <= mem[rd_idx];
   end
   assign tx_data  = tx_data_q;
   assign tx_cd    = tx_cd_q;
   assign tx_valid = tx_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign cmd_err  = cmd_err_q;
endmodule

// File: tb/tb_mkio_rt_tx.sv
// tb_mkio_rt_tx: vector table, corner sequences and random transactions scored by a
// transaction-level model of the responder (status arithmetic plus a buffer array).
module tb_mkio_rt_tx;
   localparam int P = 20;
   localparam int NSA = 4;
   typedef struct {
      logic [15:0] cmd;
      logic        perr;
      logic [3:0]  fl;
      int          kind;
      logic [15:0] sw;
      int          n;
      int          dly;
   } vec_t;
   logic clk = 1'b0, reset = 1'b0, start = 1'b0, p_error = 1'b0, tx_ack = 1'b0, wr_en = 1'b0;
   logic sreq = 1'b0, ss_flag = 1'b0, t_flag = 1'b0, dbca = 1'b0;
   logic [15:0] rx_data = '0, wr_data = '0;
   logic [4:0] wr_sa = '0, wr_addr = '0;
   logic [15:0] tx_data;
   logic tx_cd, tx_valid, busy, done, cmd_err;
   int tests = 0, fails = 0;
   logic [15:0] mem_m [1:NSA][32];
   logic bcr_m = 1'b0;
   vec_t v [12];

   mkio_rt_tx #(.ADDRESS(5'd1), .NUM_SA(NSA), .PAUSE_CYCLES(8'(P))) dut (
      .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .p_error(p_error),
      .sreq(sreq), .ss_flag(ss_flag), .t_flag(t_flag), .dbca(dbca),
      .wr_en(wr_en), .wr_sa(wr_sa), .wr_addr(wr_addr), .wr_data(wr_data),
      .tx_data(tx_data), .tx_cd(tx_cd), .tx_valid(tx_valid), .tx_ack(tx_ack),
      .busy(busy), .done(done), .cmd_err(cmd_err));

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wr(input int sa, input int a, input logic [15:0] d);
      wr_en = 1'b1; wr_sa = 5'(sa); wr_addr = 5'(a); wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      if (sa >= 1 && sa <= NSA) mem_m[sa][a] = d;
   endtask

   function automatic void model(input logic [15:0] cmd, input logic perr, input logic [3:0] fl,
                                 output int kind, output logic [15:0] sw, output int n);
      int sa = int'(cmd[9:5]);
      int wc = int'(cmd[4:0]);
      int me = (sa > NSA && sa < 31) ? 1 : 0;
      kind = 0; sw = '0; n = 0;
      if (perr) kind = 1;
      else if (cmd[15:11] == 5'd1 && cmd[10]) begin
         kind = 2;
         sw = 16'(1 * 2048 + me * 1024 + int'(fl[3]) * 256 + int'(bcr_m) * 16
                  + int'(fl[2]) * 4 + int'(fl[1]) * 2 + int'(fl[0]));
         n = (sa >= 1 && sa <= NSA) ? (wc == 0 ? 32 : wc) : 0;
      end
   endfunction

   task automatic issue(input logic [15:0] cmd, input logic perr);
      rx_data = cmd; p_error = perr; start = 1'b1;
      @(negedge clk);
      start = 1'b0; p_error = 1'b0;
      if (cmd[15:11] == 5'd31 && !perr) bcr_m = 1'b1;
   endtask

   // kind: 0 silent, 1 parity reject, 2 reply of status plus n data words.
   task automatic serve(input logic [15:0] cmd, input int kind, input logic [15:0] sw, input int n,
                        input int dly, input int stop_at, input logic spur, input logic coll);
      int c = 0, c_ack = 0, sa = int'(cmd[9:5]), pend_a = -1;
      logic [15:0] exp, d0, pend_d = '0;
      logic seen = 1'b0;
      chk("busy_on_start", 32'(busy), 32'(1));
      chk("valid_drop_on_start", 32'(tx_valid), 32'(0));
      if (kind != 2) begin
         for (int k = 1; k <= P + 4; k++) begin
            @(negedge clk);
            seen |= tx_valid;
            if (k == 1) chk("cmd_err_pulse", 32'(cmd_err), 32'(kind == 1));
            if (k == 2) begin
               chk("cmd_err_end", 32'(cmd_err), 32'(0));
               chk("busy_idle", 32'(busy), 32'(0));
            end
         end
         chk("no_reply", 32'(seen), 32'(0));
         return;
      end
      for (int i = 0; i <= n; i++) begin
         exp = (i == 0) ? sw : mem_m[sa][i - 1];
         while (!tx_valid && c - c_ack < P + 4) begin
            tx_ack = spur && i == 0 && c < P - 1;
            @(negedge clk);
            wr_en = 1'b0;
            c++;
         end
         tx_ack = 1'b0; wr_en = 1'b0;
         chk("valid_rise", 32'(tx_valid), 32'(1));
         if (!tx_valid) return;
         chk(i == 0 ? "sw_latency" : "dw_gap", 32'(c - c_ack), 32'(i == 0 ? P : 2));
         if (i == stop_at) return;
         chk(i == 0 ? "sw_data" : "dw_data", 32'(tx_data), 32'(exp));
         chk("cd", 32'(tx_cd), 32'(i == 0));
         if (pend_a >= 0) begin
            mem_m[sa][pend_a] = pend_d;
            pend_a = -1;
         end
         d0 = tx_data;
         repeat (dly) begin
            @(negedge clk); c++;
            chk("hold", {15'd0, tx_valid, tx_data}, {15'd0, 1'b1, d0});
         end
         tx_ack = 1'b1;
         @(negedge clk); c++;
         tx_ack = 1'b0; c_ack = c;
         if (i == 0 && sw[4]) bcr_m = 1'b0;
         if (coll && i < n) begin
            pend_a = i; pend_d = ~mem_m[sa][i];
            wr_en = 1'b1; wr_sa = 5'(sa); wr_addr = 5'(i); wr_data = pend_d;
         end
         if (i == n) begin
            chk("done", 32'(done), 32'(1));
            chk("busy_end", 32'(busy), 32'(0));
            @(negedge clk);
            chk("done_pulse", 32'(done), 32'(0));
         end else chk("valid_drop", 32'(tx_valid), 32'(0));
      end
   endtask

   initial begin
      int kind, n;
      logic [15:0] sw, cmd;
      logic [4:0] a5, sa5, wc;
      logic [3:0] fl;
      logic perr;
      v[0]  = '{16'h0C43, 1'b0, 4'h0, 2, 16'h0800, 3, 0};
      v[1]  = '{16'h0C40, 1'b0, 4'h0, 2, 16'h0800, 32, 1};
      v[2]  = '{16'hFC43, 1'b0, 4'h0, 0, 16'h0000, 0, 0};
      v[3]  = '{16'h0C41, 1'b0, 4'h0, 2, 16'h0810, 1, 0};
      v[4]  = '{16'h0C41, 1'b0, 4'h0, 2, 16'h0800, 1, 0};
      v[5]  = '{16'h0C43, 1'b1, 4'h0, 1, 16'h0000, 0, 0};
      v[6]  = '{16'h1443, 1'b0, 4'h0, 0, 16'h0000, 0, 0};
      v[7]  = '{16'h0CA1, 1'b0, 4'h0, 2, 16'h0C00, 0, 0};
      v[8]  = '{16'h0C01, 1'b0, 4'h0, 2, 16'h0800, 0, 0};
      v[9]  = '{16'h0C43, 1'b0, 4'hF, 2, 16'h0907, 3, 10};
      v[10] = '{16'h0843, 1'b0, 4'h0, 0, 16'h0000, 0, 0};
      v[11] = '{16'h0FE1, 1'b0, 4'h0, 2, 16'h0800, 0, 0};
      repeat (3) @(negedge clk);
      chk("reset_state", {11'd0, tx_valid, tx_cd, busy, done, cmd_err, tx_data}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      for (int s = 1; s <= NSA; s++)
         for (int a = 0; a < 32; a++)
            wr(s, a, (s == 2 && a < 3) ? 16'(32'hA001 + 32'(a)) : 16'($urandom));
      foreach (v[i]) begin
         {sreq, ss_flag, dbca, t_flag} = v[i].fl;
         issue(v[i].cmd, v[i].perr);
         serve(v[i].cmd, v[i].kind, v[i].sw, v[i].n, v[i].dly, -1, 1'b0, 1'b0);
      end
      {sreq, ss_flag, dbca, t_flag} = 4'h0;
      issue(16'h0C43, 1'b0);
      serve(16'h0C43, 2, 16'h0800, 3, 0, 2, 1'b0, 1'b0);
      issue(16'h0C41, 1'b0);
      serve(16'h0C41, 2, 16'h0800, 1, 0, -1, 1'b0, 1'b0);
      issue(16'h0C44, 1'b0);
      serve(16'h0C44, 2, 16'h0800, 4, 1, -1, 1'b1, 1'b1);
      issue(16'h0C44, 1'b0);
      serve(16'h0C44, 2, 16'h0800, 4, 0, -1, 1'b0, 1'b0);
      issue(16'h0C43, 1'b0);
      serve(16'h0C43, 2, 16'h0800, 3, 0, 1, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      chk("reset_mid_word", {11'd0, tx_valid, tx_cd, busy, done, cmd_err, tx_data}, 32'd0);
      @(negedge clk);
      reset = 1'b1; bcr_m = 1'b0;
      issue(16'h0C43, 1'b0);
      serve(16'h0C43, 2, 16'h0800, 3, 0, -1, 1'b0, 1'b0);
      wr(5, 0, 16'hDEAD);
      wr(0, 1, 16'hBEEF);
      issue(16'h0C21, 1'b0);
      serve(16'h0C21, 2, 16'h0800, 1, 0, -1, 1'b0, 1'b0);
      issue(16'h0C82, 1'b0);
      serve(16'h0C82, 2, 16'h0800, 2, 0, -1, 1'b0, 1'b0);
      repeat (40) begin
         repeat ($urandom_range(0, 3))
            wr(int'($urandom_range(0, 6)), int'($urandom_range(0, 31)), 16'($urandom));
         case ($urandom_range(0, 7))
            0: a5 = 5'd31;
            1: a5 = 5'd2;
            default: a5 = 5'd1;
         endcase
         sa5  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
         wc   = 5'($urandom_range(0, 7));
         perr = $urandom_range(0, 7) == 0;
         fl   = 4'($urandom);
         cmd  = {a5, $urandom_range(0, 5) != 0, sa5, wc};
         model(cmd, perr, fl, kind, sw, n);
         {sreq, ss_flag, dbca, t_flag} = fl;
         issue(cmd, perr);
         serve(cmd, kind, sw, n, int'($urandom_range(0, 3)), -1,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
